// File: rtl/mac_lanes.sv
// mac_lanes: LANES signed multiply-accumulate lanes fed by one broadcast activation.
// Optional build macro MAC_LANES_SAT_EN: sticky saturating accumulators instead of wrap.
module mac_lanes #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned LEN_W  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [LEN_W-1:0]        len_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [DATA_W-1:0]       in_data_i,
  input  logic [LANES*DATA_W-1:0] in_weight_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [LANES*ACC_W-1:0]  out_data_o,
  output logic                    busy_o
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned SUM_W  = ACC_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DRAIN,
    OUT
  } state_e;

  state_e                   state_q, state_d;
  logic [LEN_W-1:0]         cnt_q, cnt_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic                     prod_vld_q, prod_vld_d;
  logic signed [PROD_W-1:0] prod_q [LANES];
  logic signed [PROD_W-1:0] prod_d [LANES];
  logic signed [ACC_W-1:0]  acc_q  [LANES];
  logic signed [ACC_W-1:0]  acc_d  [LANES];
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic                     busy_q, busy_d;
  logic [LANES*ACC_W-1:0]   out_data_q, out_data_d;

  logic                     accept_c;
  logic signed [PROD_W-1:0] act_ext_c;
  logic signed [PROD_W-1:0] wgt_ext_c [LANES];

`ifdef MAC_LANES_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [LANES-1:0]         sat_q, sat_d;
  logic signed [SUM_W-1:0]  sum_c [LANES];
`endif

  assign accept_c = in_valid_i && in_ready_q;

  // Sign-extend operands to product width so the multiply is a plain signed one.
  always_comb begin
    act_ext_c = PROD_W'($signed(in_data_i));
    for (int k = 0; k < LANES; k++) begin
      wgt_ext_c[k] = PROD_W'($signed(in_weight_i[k*DATA_W +: DATA_W]));
    end
  end

  // Next-state: stage-1 products, stage-2 accumulate, control FSM, registered outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    prod_vld_d = 1'b0;
    out_data_d = out_data_q;
    for (int k = 0; k < LANES; k++) begin
      prod_d[k] = prod_q[k];
      acc_d[k]  = acc_q[k];
    end
`ifdef MAC_LANES_SAT_EN
    sat_d = sat_q;
    for (int k = 0; k < LANES; k++) begin
      sum_c[k] = SUM_W'(acc_q[k]) + SUM_W'(prod_q[k]);
    end
`endif

    if (accept_c) begin
      prod_vld_d = 1'b1;
      for (int k = 0; k < LANES; k++) begin
        prod_d[k] = act_ext_c * wgt_ext_c[k];
      end
    end

    if (prod_vld_q) begin
      for (int k = 0; k < LANES; k++) begin
`ifdef MAC_LANES_SAT_EN
        if (!sat_q[k]) begin
          if (sum_c[k][ACC_W] != sum_c[k][ACC_W-1]) begin
            acc_d[k] = sum_c[k][ACC_W] ? ACC_MIN : ACC_MAX;
            sat_d[k] = 1'b1;
          end else begin
            acc_d[k] = sum_c[k][ACC_W-1:0];
          end
        end
`else
        acc_d[k] = acc_q[k] + ACC_W'(prod_q[k]);
`endif
      end
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          cnt_d      = '0;
          len_d      = len_i;
          prod_vld_d = 1'b0;
          for (int k = 0; k < LANES; k++) begin
            acc_d[k] = '0;
          end
`ifdef MAC_LANES_SAT_EN
          sat_d = '0;
`endif
          if (len_i == '0) begin
            state_d    = OUT;
            out_data_d = '0;
          end else begin
            state_d = ACC;
          end
        end
      end
      ACC: begin
        if (accept_c) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Leave once the last product has landed in the accumulators.
        if (!prod_vld_q) begin
          state_d = OUT;
          for (int k = 0; k < LANES; k++) begin
            out_data_d[k*ACC_W +: ACC_W] = acc_q[k];
          end
        end
      end
      OUT: begin
        if (out_ready_i) begin
          state_d    = IDLE;
          out_data_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == ACC);
    out_valid_d = (state_d == OUT);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      prod_vld_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= '0;
      for (int k = 0; k < LANES; k++) begin
        prod_q[k] <= '0;
        acc_q[k]  <= '0;
      end
`ifdef MAC_LANES_SAT_EN
      sat_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      prod_vld_q  <= prod_vld_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      out_data_q  <= out_data_d;
      for (int k = 0; k < LANES; k++) begin
        prod_q[k] <= prod_d[k];
        acc_q[k]  <= acc_d[k];
      end
`ifdef MAC_LANES_SAT_EN
      sat_q <= sat_d;
`endif
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_mac_lanes.sv
// tb_mac_lanes: randomized scoreboard bench for mac_lanes, plus a narrow-accumulator
// instance exercising wrap/saturation (MAC_LANES_SAT_EN selects the expected behaviour).
`timescale 1ns/1ps
module tb_mac_lanes;
  localparam int unsigned LANES   = 4;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ACC_W   = 32;
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned S_ACC_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst_i, start_i, in_valid_i, out_ready_i;
  logic [LEN_W-1:0]        len_i;
  logic [DATA_W-1:0]       in_data_i;
  logic [LANES*DATA_W-1:0] in_weight_i;
  logic                    in_ready_o, out_valid_o, busy_o;
  logic [LANES*ACC_W-1:0]  out_data_o;

  logic                    s_start_i, s_in_valid_i, s_out_ready_i;
  logic [LEN_W-1:0]        s_len_i;
  logic [DATA_W-1:0]       s_in_data_i, s_in_weight_i;
  logic                    s_in_ready_o, s_out_valid_o, s_busy_o;
  logic [S_ACC_W-1:0]      s_out_data_o;

  mac_lanes #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .len_i(len_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .in_weight_i(in_weight_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .busy_o(busy_o)
  );

  mac_lanes #(.LANES(1), .DATA_W(DATA_W), .ACC_W(S_ACC_W), .LEN_W(LEN_W)) u_narrow (
    .clk_i(clk), .rst_i(rst_i), .start_i(s_start_i), .len_i(s_len_i),
    .in_valid_i(s_in_valid_i), .in_ready_o(s_in_ready_o), .in_data_i(s_in_data_i),
    .in_weight_i(s_in_weight_i), .out_valid_o(s_out_valid_o), .out_ready_i(s_out_ready_i),
    .out_data_o(s_out_data_o), .busy_o(s_busy_o)
  );

  int n_vec = 0;
  int n_mis = 0;
  int cyc = 0;
  int exp_rise = 0;
  int n_done = 0;
  logic hold_mode = 1'b0;
  logic [LANES*ACC_W-1:0] exp_q [$];
  logic signed [DATA_W-1:0] d_a [256];
  logic signed [DATA_W-1:0] w_a [256][LANES];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: exact dot product, then either clamp-and-stick or wrap on truncation.
  function automatic longint lane_ref(input int n, input int lane, input int acc_w);
    longint s;
    longint p;
`ifdef MAC_LANES_SAT_EN
    longint mx;
    longint mn;
    bit stuck;
    mx = (longint'(1) <<< (acc_w - 1)) - 1;
    mn = -mx - 1;
    stuck = 1'b0;
`endif
    s = 0;
    for (int i = 0; i < n; i++) begin
      p = longint'(d_a[i]) * longint'(w_a[i][lane]);
`ifdef MAC_LANES_SAT_EN
      if (!stuck) begin
        s = s + p;
        if (s > mx) begin s = mx; stuck = 1'b1; end
        else if (s < mn) begin s = mn; stuck = 1'b1; end
      end
`else
      s = s + p;
`endif
    end
    return s;
  endfunction

  // Downstream ready: random unless a run holds it off.
  always @(posedge clk) begin
    #2;
    out_ready_i = hold_mode ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops the scoreboard on each new result and polices the output protocol.
  logic prev_v = 1'b0;
  logic hs_prev = 1'b0;
  logic [LANES*ACC_W-1:0] held = '0;
  always @(negedge clk) begin
    if (rst_i) begin
      prev_v  = 1'b0;
      hs_prev = 1'b0;
    end else begin
      if (hs_prev) chk("valid_drop", out_valid_o, 1'b0);
      if (!out_valid_o) begin
        chk("data_zero_when_invalid", out_data_o, '0);
      end else if (!prev_v) begin
        chk("latency", cyc, exp_rise);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_mis++;
          $display("FAIL unexpected_result: got %0h with nothing expected", out_data_o);
        end else begin
          chk("result", out_data_o, exp_q.pop_front());
        end
        held = out_data_o;
      end else begin
        chk("data_hold", out_data_o, held);
      end
      hs_prev = out_valid_o && out_ready_i;
      if (hs_prev) n_done++;
      prev_v = out_valid_o;
    end
  end

  task automatic gap(input int n);
    repeat (n) begin
      in_valid_i  = 1'b0;
      in_data_i   = DATA_W'($urandom);
      in_weight_i = LANES*DATA_W'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) begin
      d_a[i] = DATA_W'($urandom);
      for (int k = 0; k < LANES; k++) w_a[i][k] = DATA_W'($urandom);
    end
  endtask

  // gap_mode: 0 back-to-back, 1 random gaps, 2 one-cycle gap between beats.
  task automatic run(input int len, input int gap_mode, input bit hold, input int abort_at);
    logic [LANES*ACC_W-1:0] e;
    int t;
    int d0;
    bit rdy;
    e = '0;
    for (int k = 0; k < LANES; k++) e[k*ACC_W +: ACC_W] = ACC_W'(lane_ref(len, k, ACC_W));
    if (abort_at < 0) exp_q.push_back(e);
    hold_mode = hold;
    d0 = n_done;
    @(posedge clk); #1;
    start_i = 1'b1;
    len_i   = LEN_W'(len);
    @(posedge clk); #1;
    start_i = 1'b0;
    len_i   = LEN_W'($urandom);
    if (len == 0) exp_rise = cyc;
    for (int i = 0; i < len; i++) begin
      if (gap_mode == 2 && i > 0) gap(1);
      else if (gap_mode == 1) gap($urandom_range(0, 2));
      in_valid_i = 1'b1;
      in_data_i  = d_a[i];
      for (int k = 0; k < LANES; k++) in_weight_i[k*DATA_W +: DATA_W] = w_a[i][k];
      t = 0;
      rdy = 1'b0;
      while (!rdy && t < 1000) begin
        @(negedge clk);
        chk("busy_in_run", busy_o, 1'b1);
        rdy = in_ready_o;
        @(posedge clk); #1;
        t++;
      end
      chk("beat_accepted", rdy, 1'b1);
      in_valid_i = 1'b0;
      in_data_i  = DATA_W'($urandom);
      if (i == len - 1) exp_rise = cyc + 2;
      if (i + 1 == abort_at) begin
        rst_i   = 1'b1;
        start_i = 1'b1;
        len_i   = '0;
        @(posedge clk); #1;
        rst_i   = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", in_ready_o, 1'b0);
        chk("abort_out_valid", out_valid_o, 1'b0);
        chk("abort_out_data", out_data_o, '0);
        chk("abort_busy", busy_o, 1'b0);
        hold_mode = 1'b0;
        return;
      end
    end
    if (hold) begin
      t = 0;
      while (!out_valid_o && t < 100) begin @(negedge clk); t++; end
      @(posedge clk); #1;
      start_i = 1'b1;
      len_i   = LEN_W'(2);
      @(posedge clk); #1;
      start_i = 1'b0;
      repeat (4) @(posedge clk);
      #1 hold_mode = 1'b0;
    end
    t = 0;
    while (n_done == d0 && t < 2000) begin
      @(negedge clk);
      if (len == 0) chk("ready_low_len0", in_ready_o, 1'b0);
      @(posedge clk);
      t++;
    end
    chk("handshake_seen", n_done != d0, 1'b1);
    @(negedge clk);
    chk("idle_after_handshake", busy_o, 1'b0);
  endtask

  initial begin
    logic [S_ACC_W-1:0] es;
    int cnt;
    int t;
    bit r;
    int len;
    rst_i = 1'b1; start_i = 1'b0; len_i = '0; in_valid_i = 1'b0;
    in_data_i = '0; in_weight_i = '0;
    s_start_i = 1'b0; s_len_i = '0; s_in_valid_i = 1'b0;
    s_in_data_i = '0; s_in_weight_i = '0; s_out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", in_ready_o, 1'b0);
    chk("reset_out_valid", out_valid_o, 1'b0);
    chk("reset_out_data", out_data_o, '0);
    chk("reset_busy", busy_o, 1'b0);

    for (int i = 0; i < 3; i++) begin
      d_a[i] = DATA_W'(i + 1);
      for (int k = 0; k < LANES; k++) w_a[i][k] = DATA_W'(k + 1);
    end
    run(3, 0, 1'b0, -1);

    for (int i = 0; i < 4; i++) begin
      d_a[i] = -8'sd5;
      for (int k = 0; k < LANES; k++) w_a[i][k] = 8'sd7;
    end
    run(4, 2, 1'b0, -1);

    fill_rand(6);
    run(6, 1, 1'b1, -1);

    run(0, 0, 1'b0, -1);

    fill_rand(5);
    run(5, 0, 1'b0, 2);
    d_a[0] = 8'sd2;
    for (int k = 0; k < LANES; k++) w_a[0][k] = 8'sd3;
    run(1, 0, 1'b0, -1);

    for (int r2 = 0; r2 < 40; r2++) begin
      len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 20));
      fill_rand(len);
      run(len, int'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0), -1);
    end

    for (int i = 0; i < 200; i++) begin
      d_a[i] = 8'sd127;
      w_a[i][0] = 8'sd127;
    end
    es = S_ACC_W'(lane_ref(200, 0, S_ACC_W));
    @(posedge clk); #1;
    s_start_i = 1'b1;
    s_len_i   = LEN_W'(200);
    @(posedge clk); #1;
    s_start_i     = 1'b0;
    s_in_valid_i  = 1'b1;
    s_in_data_i   = 8'd127;
    s_in_weight_i = 8'd127;
    cnt = 0;
    t = 0;
    while (cnt < 200 && t < 1000) begin
      @(negedge clk);
      r = s_in_ready_o;
      @(posedge clk); #1;
      if (r) cnt++;
      t++;
    end
    s_in_valid_i = 1'b0;
    chk("narrow_beats", cnt, 200);
    t = 0;
    while (!s_out_valid_o && t < 100) begin @(negedge clk); t++; end
    chk("narrow_valid", s_out_valid_o, 1'b1);
    chk("narrow_result", s_out_data_o, es);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
